// File: rtl/parity_job_scheduler.sv
// parity_job_scheduler: round-robin front end that runs one parity job at a time
// on an AXI4-Lite master (write DATA, read PARITY) and returns parity plus error.
// Ports: s00_axi_aclk/areset, req_valid/data/ready (2 requesters),
// rsp_valid/id/parity/err/ready (result), m_axi_* (AXI4-Lite master).
module parity_job_scheduler #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned DATA_OFFSET   = 'h0,
  parameter int unsigned PARITY_OFFSET = 'h4
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_areset,
  input  logic [1:0]            req_valid,
  input  logic [63:0]           req_data,
  output logic [1:0]            req_ready,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic                  rsp_parity,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [ADDR_WIDTH-1:0] DATA_ADDR =
    ADDR_WIDTH'(BASE_ADDR + DATA_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] PAR_ADDR =
    ADDR_WIDTH'(BASE_ADDR + PARITY_OFFSET);

  typedef enum logic [2:0] {
    IDLE, WRITE, BRESP, READ, RDATA, RESP
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q;
  logic        id_q;
  logic [31:0] op_q;
  logic        aw_done_q, w_done_q;
  logic        par_q, err_q;
  logic        gsel;

  // Only bit 0 of the PARITY register carries information.
  logic unused_rdata;
  assign unused_rdata = ^m_axi_rdata[31:1];

  // Pointer side wins a tie; a lone requester wins outright.
  always_comb begin
    gsel = req_valid[1];
    if (&req_valid) gsel = ptr_q;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 2'b00;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = WRITE;
          req_ready[gsel] = ~s00_axi_areset;
        end
      end
      WRITE: begin
        m_axi_awvalid = ~aw_done_q;
        m_axi_wvalid  = ~w_done_q;
        if ((aw_done_q || m_axi_awready) &&
            (w_done_q || m_axi_wready))
          state_d = BRESP;
      end
      BRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = READ;
      end
      READ: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = RDATA;
      end
      RDATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      id_q      <= 1'b0;
      op_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      par_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            ptr_q     <= ~gsel;
            id_q      <= gsel;
            op_q      <= gsel ? req_data[63:32] : req_data[31:0];
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        WRITE: begin
          if (m_axi_awvalid && m_axi_awready) aw_done_q <= 1'b1;
          if (m_axi_wvalid && m_axi_wready) w_done_q <= 1'b1;
        end
        BRESP: if (m_axi_bvalid) err_q <= |m_axi_bresp;
        RDATA: begin
          if (m_axi_rvalid) begin
            par_q <= m_axi_rdata[0];
            err_q <= err_q | (|m_axi_rresp);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_id       = id_q;
  assign rsp_parity   = par_q;
  assign rsp_err      = err_q;
  assign m_axi_awaddr = m_axi_awvalid ? DATA_ADDR : '0;
  assign m_axi_araddr = m_axi_arvalid ? PAR_ADDR : '0;
  assign m_axi_wdata  = op_q;
  assign m_axi_wstrb  = 4'hF;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

endmodule

// File: tb/tb_parity_job_scheduler.sv
// tb_parity_job_scheduler: randomized + directed bench with a behavioural
// AXI4-Lite parity slave, a round-robin reference model and a scoreboard.
module tb_parity_job_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        rsp_valid, rsp_id, rsp_parity, rsp_err, rsp_ready;
  logic [3:0]  m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  parity_job_scheduler dut (
    .s00_axi_aclk  (clk),
    .s00_axi_areset(rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_parity    (rsp_parity),
    .rsp_err       (rsp_err),
    .rsp_ready     (rsp_ready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  typedef struct {
    logic [31:0] op;
    int          awd, wd, bd, ard, rd;
    logic [1:0]  bresp, rresp;
  } plan_t;

  typedef struct {
    bit id;
    bit par;
    bit err;
    bit zw;
    int gcyc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          issue_left[2];
  bit          granted[2];
  int          issue_pct = 100;
  int          rsp_pct = 100;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;

  bit         rand_knobs = 1'b0;
  int         k_awd = 0, k_wd = 0, k_bd = 0, k_ard = 0, k_rd = 0;
  logic [1:0] k_bresp = 2'b00, k_rresp = 2'b00;

  bit busy = 1'b0;
  bit mptr = 1'b0;
  bit seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog got=%0d want=0", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  // Requesters: hold valid/data until granted, then optionally reissue.
  initial begin
    req_valid = 2'b00;
    req_data  = '0;
    rsp_ready = 1'b1;
    issue_left[0] = 0;
    issue_left[1] = 0;
    granted[0] = 1'b0;
    granted[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (granted[n]) begin
          req_valid[n] = 1'b0;
          granted[n]   = 1'b0;
        end
        if (!req_valid[n] && issue_left[n] > 0 &&
            $urandom_range(0, 99) < issue_pct) begin
          req_valid[n] = 1'b1;
          req_data[32*n +: 32] = fixed_en ? fixed_data : $urandom;
          issue_left[n]--;
        end
      end
      rsp_ready = $urandom_range(0, 99) < rsp_pct;
    end
  end

  // Behavioural parity_generator slave following a per-job plan.
  plan_t       pl;
  bit          sl_act = 1'b0;
  int          ph = 0;
  int          awc, wc, bc, arc, rc;
  bit          aw_got, w_got;
  logic [31:0] mem = '0;

  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
    m_axi_bresp = 0; m_axi_arready = 0; m_axi_rvalid = 0;
    m_axi_rdata = 0; m_axi_rresp = 0;
    forever begin
      @(negedge clk);
      #1;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      m_axi_arready = 0; m_axi_rvalid = 0;
      if (rst) begin
        sl_act = 1'b0;
        plan_q.delete();
        continue;
      end
      if (!sl_act && (m_axi_awvalid || m_axi_wvalid)) begin
        if (plan_q.size() == 0) begin
          chk(1'b0, "unexpected_write", 1, 0);
        end else begin
          pl = plan_q.pop_front();
          sl_act = 1'b1; ph = 0;
          awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
          aw_got = 1'b0; w_got = 1'b0;
        end
      end
      if (!sl_act) begin
        chk(!(m_axi_awvalid | m_axi_wvalid | m_axi_arvalid |
              m_axi_bready | m_axi_rready), "idle_bus",
            {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
             m_axi_bready, m_axi_rready}, 0);
      end else if (ph == 0) begin
        chk(!(m_axi_arvalid | m_axi_bready | m_axi_rready),
            "w_phase_other",
            {m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
        if (!aw_got) begin
          chk(m_axi_awvalid, "awvalid_held", m_axi_awvalid, 1);
          if (m_axi_awvalid && awc >= pl.awd) begin
            m_axi_awready = 1'b1;
            aw_got = 1'b1;
            chk(m_axi_awaddr == 4'h0 && m_axi_awprot == 3'd0,
                "awaddr", {m_axi_awprot, m_axi_awaddr}, 0);
          end
          awc++;
        end else begin
          chk(!m_axi_awvalid, "awvalid_drop", m_axi_awvalid, 0);
        end
        if (!w_got) begin
          chk(m_axi_wvalid, "wvalid_held", m_axi_wvalid, 1);
          if (m_axi_wvalid && wc >= pl.wd) begin
            m_axi_wready = 1'b1;
            w_got = 1'b1;
            mem = m_axi_wdata;
            chk(m_axi_wdata == pl.op, "wdata", m_axi_wdata, pl.op);
            chk(m_axi_wstrb == 4'hF, "wstrb", m_axi_wstrb, 4'hF);
          end
          wc++;
        end else begin
          chk(!m_axi_wvalid, "wvalid_drop", m_axi_wvalid, 0);
        end
        if (aw_got && w_got) ph = 1;
      end else if (ph == 1) begin
        chk(!(m_axi_awvalid | m_axi_wvalid | m_axi_arvalid |
              m_axi_rready), "b_phase_other",
            {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
             m_axi_rready}, 0);
        if (bc >= pl.bd) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = pl.bresp;
          chk(m_axi_bready, "bready", m_axi_bready, 1);
          if (m_axi_bready) ph = 2;
        end
        bc++;
      end else if (ph == 2) begin
        chk(!(m_axi_awvalid | m_axi_wvalid | m_axi_bready |
              m_axi_rready), "ar_phase_other",
            {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
             m_axi_rready}, 0);
        chk(m_axi_arvalid, "arvalid_held", m_axi_arvalid, 1);
        if (m_axi_arvalid && arc >= pl.ard) begin
          m_axi_arready = 1'b1;
          chk(m_axi_araddr == 4'h4 && m_axi_arprot == 3'd0,
              "araddr", {m_axi_arprot, m_axi_araddr}, 4'h4);
          ph = 3;
        end
        arc++;
      end else begin
        chk(!(m_axi_awvalid | m_axi_wvalid | m_axi_arvalid |
              m_axi_bready), "r_phase_other",
            {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
             m_axi_bready}, 0);
        if (rc >= pl.rd) begin
          m_axi_rvalid = 1'b1;
          m_axi_rresp  = pl.rresp;
          m_axi_rdata  = {31'($urandom), ^mem};
          chk(m_axi_rready, "rready", m_axi_rready, 1);
          if (m_axi_rready) sl_act = 1'b0;
        end
        rc++;
      end
    end
  end

  // Reference model: round-robin grant prediction + response scoreboard.
  bit         g;
  logic [1:0] want_rdy;
  plan_t      np;
  exp_t       ne, fe;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        exp_q.delete();
        busy = 1'b0;
        mptr = 1'b0;
        seen = 1'b0;
        continue;
      end
      if (!busy && req_valid != 2'b00) begin
        g = (req_valid == 2'b11) ? mptr : req_valid[1];
        want_rdy = g ? 2'b10 : 2'b01;
        chk(req_ready == want_rdy, "grant", req_ready, want_rdy);
        mptr = !g;
        busy = 1'b1;
        granted[g] = 1'b1;
        np.op = g ? req_data[63:32] : req_data[31:0];
        if (rand_knobs) begin
          np.awd = $urandom_range(0, 4);
          np.wd  = $urandom_range(0, 4);
          np.bd  = $urandom_range(0, 4);
          np.ard = $urandom_range(0, 3);
          np.rd  = $urandom_range(0, 3);
          np.bresp = ($urandom_range(0, 3) == 0) ?
                     2'($urandom_range(1, 3)) : 2'd0;
          np.rresp = ($urandom_range(0, 3) == 0) ?
                     2'($urandom_range(1, 3)) : 2'd0;
        end else begin
          np.awd = k_awd; np.wd = k_wd; np.bd = k_bd;
          np.ard = k_ard; np.rd = k_rd;
          np.bresp = k_bresp; np.rresp = k_rresp;
        end
        plan_q.push_back(np);
        ne.id   = g;
        ne.par  = ^np.op;
        ne.err  = (np.bresp != 2'd0) || (np.rresp != 2'd0);
        ne.zw   = (np.awd + np.wd + np.bd + np.ard + np.rd) == 0;
        ne.gcyc = cyc;
        exp_q.push_back(ne);
      end else begin
        chk(req_ready == 2'b00, "no_grant", req_ready, 0);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "rsp_unexpected", 1, 0);
        end else begin
          fe = exp_q[0];
          chk(rsp_id == fe.id, "rsp_id", rsp_id, fe.id);
          chk(rsp_parity == fe.par, "rsp_parity", rsp_parity, fe.par);
          chk(rsp_err == fe.err, "rsp_err", rsp_err, fe.err);
          if (!seen && fe.zw)
            chk(cyc - fe.gcyc == 5, "latency", cyc - fe.gcyc, 5);
          seen = 1'b1;
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while ((issue_left[0] != 0 || issue_left[1] != 0 ||
            req_valid != 2'b00 || busy) && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk(n < budget, "timeout", n, budget);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk({req_ready, rsp_valid, rsp_id, rsp_parity, rsp_err,
         m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
         m_axi_rready, m_axi_awaddr, m_axi_araddr, m_axi_wdata,
         m_axi_awprot, m_axi_arprot} == '0, "reset_outputs",
        {req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid,
         m_axi_arvalid}, 0);
    @(negedge clk);
    #3 rst = 1'b0;

    // single zero-wait job, operand 7
    fixed_en = 1'b1;
    fixed_data = 32'h0000_0007;
    issue_left[0] = 1;
    wait_done(200);
    fixed_en = 1'b0;

    // both requesters held valid from a fresh pointer: 0,1,0,1
    pulse_reset();
    issue_left[0] = 2;
    issue_left[1] = 2;
    wait_done(300);

    // W accepted 3 cycles before AW, late B
    k_awd = 3;
    k_bd = 5;
    issue_left[1] = 1;
    wait_done(200);
    k_awd = 0;
    k_bd = 0;

    // write SLVERR, read OKAY
    k_bresp = 2'b10;
    issue_left[0] = 1;
    wait_done(200);
    k_bresp = 2'b00;

    // consumer stalls with requester 1 pending
    rsp_pct = 0;
    issue_left[0] = 1;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!rsp_valid && n < 50);
    chk(rsp_valid, "stall_rsp_seen", rsp_valid, 1);
    issue_left[1] = 1;
    repeat (10) @(negedge clk);
    #3 rsp_pct = 100;
    wait_done(200);

    // reset while AW is stuck waiting for awready
    k_awd = 20;
    issue_left[0] = 1;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!m_axi_awvalid && n < 40);
    chk(m_axi_awvalid, "awvalid_before_reset", m_axi_awvalid, 1);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
         m_axi_rready, rsp_valid, req_ready} == '0, "async_reset",
        {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 0);
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
    k_awd = 0;
    issue_left[0] = 1;
    issue_left[1] = 1;
    wait_done(300);

    // randomized traffic
    rand_knobs = 1'b1;
    issue_pct = 40;
    rsp_pct = 70;
    issue_left[0] = 150;
    issue_left[1] = 150;
    wait_done(30000);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
